// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the hazard scoreboard
// Scoreboard entry layout, memory-wait FSM states and the register-match helper.
package cpu_types_pkg;

    localparam int SB_WSEL_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 regwr;
        logic [SB_WSEL_W-1:0] wsel;
        logic                 load;
        logic                 mem;
    } sb_entry_t;

    typedef enum logic [1:0] {
        MEM_RUN   = 2'd0,
        MEM_DWAIT = 2'd1,
        MEM_DDONE = 2'd2
    } mem_state_e;

    localparam sb_entry_t SB_ENTRY_NONE = '0;

    // r0 is hardwired zero, so a write to it never produces a value worth bypassing
    function automatic logic entry_writes(input sb_entry_t e, input logic [SB_WSEL_W-1:0] r);
        return e.valid && e.regwr && (e.wsel == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-control bundle between decode and the scoreboard
// master drives ID fields and memory handshakes; slave returns stall/forward controls.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int NSTAGE = 3
);
    localparam int FW = $clog2(NSTAGE);

    logic              ihit;
    logic              dhit;
    logic              flush;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [1:0]        id_src_used;
    logic              id_regwr;
    logic [REG_AW-1:0] id_wsel;
    logic              id_load;
    logic              id_mem;
    logic              adv;
    logic              ifid_flush;
    logic              bubble;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic [31:0]       perf_luse;
    logic [31:0]       perf_dwait;

    modport master (
        output ihit, dhit, flush, id_rs, id_rt, id_src_used, id_regwr, id_wsel, id_load, id_mem,
        input  adv, ifid_flush, bubble, fwd_a, fwd_b, perf_luse, perf_dwait
    );

    modport slave (
        input  ihit, dhit, flush, id_rs, id_rt, id_src_used, id_regwr, id_wsel, id_load, id_mem,
        output adv, ifid_flush, bubble, fwd_a, fwd_b, perf_luse, perf_dwait
    );

endinterface

// File: rtl/hazard_fwd_pick.sv
// rtl/hazard_fwd_pick.sv - forwarding priority matcher for one EX operand
// Picks the youngest stage (2..NSTAGE) writing the operand's register; 0 selects the register file.
module hazard_fwd_pick
    import cpu_types_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  sb_entry_t [NSTAGE:1]       i_ent,
    input  logic [SB_WSEL_W-1:0]       i_src,
    input  logic                       i_used,
    output logic [$clog2(NSTAGE)-1:0]  o_sel
);
    localparam int FW = $clog2(NSTAGE);

    // walk oldest to youngest so the smallest matching stage wins
    always_comb begin
        o_sel = '0;
        for (int k = NSTAGE; k >= 2; k--) begin
            if (i_used && entry_writes(i_ent[k], i_src))
                o_sel = FW'(k - 1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard scoreboard: load-use stall, data-wait FSM, forwarding
// Optional stall counters are built only when HAZARD_SB_PERF_EN is defined.
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    hazard_scoreboard_if.slave bus
);
    sb_entry_t [NSTAGE:1]  r_ent;
    logic [SB_WSEL_W-1:0]  r_ex_rs;
    logic [SB_WSEL_W-1:0]  r_ex_rt;
    logic [1:0]            r_ex_used;
    mem_state_e            r_state;
    mem_state_e            w_state_nxt;

    logic                  w_mem2;
    logic                  w_adv;
    logic                  w_luse;
    logic                  w_bubble;
    logic [SB_WSEL_W-1:0]  w_id_rs;
    logic [SB_WSEL_W-1:0]  w_id_rt;
    sb_entry_t             w_id_ent;

    assign w_id_rs  = SB_WSEL_W'(bus.id_rs[REG_AW-1:0]);
    assign w_id_rt  = SB_WSEL_W'(bus.id_rt[REG_AW-1:0]);
    assign w_id_ent = '{valid: 1'b1,
                        regwr: bus.id_regwr,
                        wsel:  SB_WSEL_W'(bus.id_wsel[REG_AW-1:0]),
                        load:  bus.id_load,
                        mem:   bus.id_mem};

    assign w_mem2   = r_ent[2].valid && r_ent[2].mem;
    assign w_adv    = bus.ihit && (!w_mem2 || bus.dhit || (r_state == MEM_DDONE));
    assign w_bubble = w_luse || bus.flush;

    always_comb begin
        w_luse = 1'b0;
        for (int k = 1; k < LOAD_READY; k++) begin
            if (r_ent[k].load &&
                ((bus.id_src_used[0] && entry_writes(r_ent[k], w_id_rs)) ||
                 (bus.id_src_used[1] && entry_writes(r_ent[k], w_id_rt))))
                w_luse = 1'b1;
        end
    end

    // DDONE remembers a dhit that arrived while fetch was still stalled
    always_comb begin
        w_state_nxt = r_state;
        if (w_adv) begin
            w_state_nxt = MEM_RUN;
        end else begin
            case (r_state)
                MEM_RUN: begin
                    if (bus.dhit && !bus.ihit)
                        w_state_nxt = MEM_DDONE;
                    else if (w_mem2 && !bus.dhit)
                        w_state_nxt = MEM_DWAIT;
                end
                MEM_DWAIT: begin
                    if (bus.dhit && !bus.ihit)
                        w_state_nxt = MEM_DDONE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // EX sources follow ID even on a bubble; only the entry itself is squashed
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ent     <= '0;
            r_ex_rs   <= '0;
            r_ex_rt   <= '0;
            r_ex_used <= '0;
            r_state   <= MEM_RUN;
        end else begin
            r_state <= w_state_nxt;
            if (w_adv) begin
                r_ent[1] <= w_bubble ? SB_ENTRY_NONE : w_id_ent;
                for (int k = 2; k <= NSTAGE; k++)
                    r_ent[k] <= r_ent[k-1];
                r_ex_rs   <= w_id_rs;
                r_ex_rt   <= w_id_rt;
                r_ex_used <= bus.id_src_used;
            end
        end
    end

    assign bus.adv        = w_adv;
    assign bus.ifid_flush = bus.flush;
    assign bus.bubble     = w_bubble;

    hazard_fwd_pick #(.NSTAGE(NSTAGE)) u_fwd_a (
        .i_ent  (r_ent),
        .i_src  (r_ex_rs),
        .i_used (r_ex_used[0]),
        .o_sel  (bus.fwd_a)
    );

    hazard_fwd_pick #(.NSTAGE(NSTAGE)) u_fwd_b (
        .i_ent  (r_ent),
        .i_src  (r_ex_rt),
        .i_used (r_ex_used[1]),
        .o_sel  (bus.fwd_b)
    );

`ifdef HAZARD_SB_PERF_EN
    logic [31:0] r_perf_luse;
    logic [31:0] r_perf_dwait;

    // a flush squashes the hazard, so that cycle is not a load-use stall
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_perf_luse  <= '0;
            r_perf_dwait <= '0;
        end else begin
            if (w_luse && !bus.flush && w_adv)
                r_perf_luse <= r_perf_luse + 32'd1;
            if (r_state == MEM_DWAIT)
                r_perf_dwait <= r_perf_dwait + 32'd1;
        end
    end

    assign bus.perf_luse  = r_perf_luse;
    assign bus.perf_dwait = r_perf_dwait;
`else
    assign bus.perf_luse  = '0;
    assign bus.perf_dwait = '0;
`endif

endmodule
